dmem_unit: RTL
==============

# dmem_unit

Parametrised, multi-cycle data-memory unit for the next core generation. It replaces the four single-cycle byte-lane memories with one word-organised store. Access uses a req/ready/ack handshake with a configurable wait-state count. Sub-word loads return sign-extended data, and sub-word stores are byte-addressed and use byte-lane write enables. The unit sits between execute and writeback: execute issues one load or store, then stalls until ack.

## Interface
- DEPTH, 256, number of 32-bit words; power of two, ≥4
- WAIT, 0, extra wait-state cycles per access; 0..15
- clk  in  1  clock, rising edge
- rstd  in  1  reset, asynchronous, active-low
- req  in  1  access request; sampled only while ready=1
- op  in  6  16=lw, 18=lh, 20=lb, 24=sw, 26=sh, 28=sb; any other value is unsupported
- addr  in  32  byte address; word index = addr[log2(DEPTH)+1:2], upper bits ignored (wrap modulo DEPTH)
- wdata  in  32  store data; sh uses [15:0], sb uses [7:0]
- ready  out  1  unit idle, can accept req
- ack  out  1  one-cycle completion pulse
- rdata  out  32  load result, valid while ack=1; 0 for stores and errors
- err  out  1  valid while ack=1; access rejected, no write performed

## Operation
- FSM states are IDLE, BUSY and RESP. ready=1 only in IDLE.
- In IDLE with req=1, the unit latches op, addr and wdata on the clock edge.
  - Next state is BUSY if WAIT>0, else RESP.
  - Bad accesses (unsupported op, or misaligned when checking is enabled) also go to RESP. They report err=1, write nothing and set rdata=0.
- BUSY: a wait counter loads WAIT-1 on accept and decrements each cycle. At 0, the FSM moves to RESP.
- The commit edge is the edge that enters RESP. On that edge:
  - stores write their byte lanes;
  - loads register rdata.
- RESP: ack=1 for exactly one cycle, then the FSM returns to IDLE.
- Byte order is little-endian: lane0 = bits[7:0] holds byte addr[1:0]=0.
  - sw writes all 4 lanes.
  - sh writes lanes {1,0} if addr[1]=0, else {3,2}.
  - sb writes lane addr[1:0] only.
- Load data:
  - lw returns the whole word.
  - lh returns the half selected by addr[1], sign-extended from its bit 15.
  - lb returns the byte selected by addr[1:0], sign-extended from its bit 7.
- req while ready=0 is ignored. There is no queue; the requester must hold req until it observes ready.
- Memory contents are not initialised and are not cleared by reset.

## Timing
- Reset values: state IDLE, ready=1, ack=0, rdata=0, err=0, wait counter 0.
- Latency: ack is asserted WAIT+1 cycles after the accept edge.
- Throughput: one access per WAIT+2 cycles.
- Reset mid-access (BUSY or RESP):
  - the FSM returns to IDLE immediately and no ack is issued;
  - a store that has not reached its commit edge writes nothing;
  - a store already committed stays written.
- Read-after-write: a load accepted in the IDLE cycle after a store's RESP sees the new data.
- ack never coincides with ready=1.

## Configuration
- DMEM_ALIGN_CHECK_EN, when defined:
  - lw with addr[1:0]≠0 is misaligned; lh with addr[0]=1 is misaligned.
  - A misaligned access completes at normal latency with err=1, rdata=0 and no write.
- When undefined:
  - lw/sw ignore addr[1:0], and lh/sh ignore addr[0] (the address is aligned down).
  - err is asserted only for unsupported ops.
- sb/lb are never misaligned.

## Test plan
- Reset, WAIT=0: ready=1, ack=0, rdata=0. sw addr=0x8, wdata=0x12345678, then lw addr=0x8 → ack 1 cycle after accept, rdata=0x12345678, err=0.
- Sub-word accesses:
  - sb addr=0xB, wdata=0xFF → lw 0x8 returns 0xFF345678.
  - lb 0xB returns 0xFFFFFFFF.
  - lh 0xA returns 0xFFFFFF34.
- WAIT=3: lw accepted at cycle n → ack exactly at cycle n+4. A req held through BUSY is not accepted until ready returns.
- Address wrap, DEPTH=256: sw addr=0x400 data 0xA5A5A5A5 → lw addr=0x0 returns 0xA5A5A5A5.
- Misalignment, lw addr=0x6:
  - with DMEM_ALIGN_CHECK_EN → err=1, rdata=0;
  - without → rdata = word at 0x4.
- Unsupported op / reset:
  - op=17 → err=1, no write.
  - With WAIT=4, pulse rstd low during BUSY of sw → no ack, and the target word is unchanged.

Source files
------------

// File: rtl/dmem_unit.sv
// Word-organised data memory with req/ready/ack handshake, WAIT wait states and sign-extending sub-word loads.
// Optional macro DMEM_ALIGN_CHECK_EN: reject misaligned word/half accesses with err instead of aligning them down.
module dmem_unit #(
   parameter int DEPTH = 256,
   parameter int WAIT  = 0
) (
   input  logic        clk,
   input  logic        rstd,
   input  logic        req,
   input  logic [5:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic        ack,
   output logic [31:0] rdata,
   output logic        err
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
   localparam logic [5:0] OP_LW = 6'd16, OP_LH = 6'd18, OP_LB = 6'd20;
   localparam logic [5:0] OP_SW = 6'd24, OP_SH = 6'd26, OP_SB = 6'd28;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_RESP = 2'd2} state_t;

   state_t        r_state, w_next;
   logic [5:0]    r_op;
   logic [AW+1:0] r_addr;
   logic [31:0]   r_wdata;
   logic [3:0]    r_cnt;
   logic          r_ready, r_ack, r_err;
   logic [31:0]   r_rdata;
   logic [31:0]   r_mem [DEPTH];

   logic [5:0]    w_op;
   logic [AW+1:0] w_addr;
   logic [31:0]   w_wdata, w_word, w_wlanes, w_ldata;
   logic [7:0]    w_byte;
   logic [3:0]    w_be;
   logic          w_load, w_store, w_bad, w_commit, w_we;
   logic          w_unused_addr;

   // With WAIT=0 the commit edge is the accept edge, so decode the live inputs while idle
   assign w_op          = (r_state == S_IDLE) ? op : r_op;
   assign w_addr        = (r_state == S_IDLE) ? addr[AW+1:0] : r_addr;
   assign w_wdata       = (r_state == S_IDLE) ? wdata : r_wdata;
   assign w_word        = r_mem[w_addr[AW+1:2]];
   assign w_byte        = w_word[{w_addr[1:0], 3'b000} +: 8];
   assign w_unused_addr = ^addr[31:AW+2];

   // Op decode: lane enables, replicated store data and sign-extended load data
   always_comb begin
      w_load   = 1'b0;
      w_store  = 1'b0;
      w_be     = 4'b0000;
      w_wlanes = 32'd0;
      w_ldata  = 32'd0;
      case (w_op)
         OP_LW: begin
            w_load  = 1'b1;
            w_ldata = w_word;
         end
         OP_LH: begin
            w_load  = 1'b1;
            w_ldata = w_addr[1] ? {{16{w_word[31]}}, w_word[31:16]}
                                : {{16{w_word[15]}}, w_word[15:0]};
         end
         OP_LB: begin
            w_load  = 1'b1;
            w_ldata = {{24{w_byte[7]}}, w_byte};
         end
         OP_SW: begin
            w_store  = 1'b1;
            w_be     = 4'b1111;
            w_wlanes = w_wdata;
         end
         OP_SH: begin
            w_store  = 1'b1;
            w_be     = w_addr[1] ? 4'b1100 : 4'b0011;
            w_wlanes = {2{w_wdata[15:0]}};
         end
         OP_SB: begin
            w_store  = 1'b1;
            w_be     = 4'b0001 << w_addr[1:0];
            w_wlanes = {4{w_wdata[7:0]}};
         end
         default: begin
            w_load  = 1'b0;
            w_store = 1'b0;
         end
      endcase
   end

`ifdef DMEM_ALIGN_CHECK_EN
   logic w_mis;
   assign w_mis = (((w_op == OP_LW) || (w_op == OP_SW)) && (w_addr[1:0] != 2'b00)) ||
                  (((w_op == OP_LH) || (w_op == OP_SH)) && w_addr[0]);
   assign w_bad = !(w_load || w_store) || w_mis;
`else
   assign w_bad = !(w_load || w_store);
`endif

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (req) w_next = (WAIT > 0) ? S_BUSY : S_RESP;
            else     w_next = S_IDLE;
         end
         S_BUSY: begin
            if (r_cnt == 4'd0) w_next = S_RESP;
            else               w_next = S_BUSY;
         end
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   assign w_commit = (w_next == S_RESP) && (r_state != S_RESP);
   assign w_we     = w_commit && w_store && !w_bad;

   // State, request latch, wait counter and registered response outputs
   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         r_state <= S_IDLE;
         r_ready <= 1'b1;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= 32'd0;
         r_cnt   <= 4'd0;
         r_op    <= 6'd0;
         r_addr  <= '0;
         r_wdata <= 32'd0;
      end else begin
         r_state <= w_next;
         r_ready <= (w_next == S_IDLE);
         r_ack   <= (w_next == S_RESP);
         if (r_state == S_IDLE && req) begin
            r_op    <= op;
            r_addr  <= addr[AW+1:0];
            r_wdata <= wdata;
            r_cnt   <= CNT_INIT;
         end else if (r_state == S_BUSY && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end else begin
            r_cnt <= r_cnt;
         end
         if (w_commit) begin
            r_err   <= w_bad;
            r_rdata <= (w_load && !w_bad) ? w_ldata : 32'd0;
         end else if (r_state == S_RESP) begin
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
         end else begin
            r_err   <= r_err;
            r_rdata <= r_rdata;
         end
      end
   end

   // Byte-lane writes; storage is deliberately not reset
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (w_we && w_be[b]) r_mem[w_addr[AW+1:2]][b*8 +: 8] <= w_wlanes[b*8 +: 8];
      end
   end

   assign ready = r_ready;
   assign ack   = r_ack;
   assign rdata = r_rdata;
   assign err   = r_err;
endmodule
